// File: rtl/redun_mont_pkg.sv
// -----------------------------------------------------------------------------
// redun_mont_pkg
// Shared definitions for the repeated-squaring Montgomery core and its result
// unit: word geometry, modulus P, the redundant word format produced by the
// squaring core, the canonical (carry-collapsed) result format, and the
// one-hot state encoding of the result unit.
// -----------------------------------------------------------------------------
package redun_mont_pkg;

   localparam int NUM_WRDS = 4;
   localparam int WRD_BITS = 16;

   localparam logic [NUM_WRDS*WRD_BITS-1:0] P = 64'hC1A7_0000_0000_0065;

   // Redundant form: every word carries one extra carry bit above WRD_BITS.
   typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

   // Canonical form with one spare word to hold the final collapse carry.
   typedef logic [(NUM_WRDS+1)*WRD_BITS-1:0] canon_t;

   // Word index wide enough to address every canonical word.
   localparam int IDX_W = $clog2(NUM_WRDS+1);

   // Modulus zero-extended to the canonical width so the top word reads as 0.
   localparam canon_t P_EXT = canon_t'(P);

   typedef enum logic [4:0] {
      ST_IDLE     = 5'b00001,
      ST_COUNT    = 5'b00010,
      ST_COLLAPSE = 5'b00100,
      ST_REDUCE   = 5'b01000,
      ST_OUT      = 5'b10000
   } result_state_t;

   function automatic logic [WRD_BITS-1:0] get_wrd(input canon_t v,
                                                   input logic [IDX_W-1:0] idx);
      return v[int'(idx)*WRD_BITS +: WRD_BITS];
   endfunction

endpackage

// File: rtl/redun_mont_result_unit_if.sv
// -----------------------------------------------------------------------------
// redun_mont_result_unit_if
// Bus bundle between the squaring core / downstream consumer and the result
// unit.
//   i_start, i_iter_target : start pulse and squaring count target
//   i_mul, i_mul_val       : redundant squaring result and its qualifier
//   o_busy, o_iter_cnt     : activity flag and pulses counted since start
//   o_dat, o_val, i_rdy    : reduced result with valid/ready handshake
//   o_ovf                  : result could not be brought below P
// master drives the inputs (core side / bench), slave is the result unit.
// -----------------------------------------------------------------------------
interface redun_mont_result_unit_if
   import redun_mont_pkg::*;
#(
   parameter int CNT_BITS = 64
);

   logic                         i_start;
   logic [CNT_BITS-1:0]          i_iter_target;
   redun0_t                      i_mul;
   logic                         i_mul_val;
   logic                         o_busy;
   logic [CNT_BITS-1:0]          o_iter_cnt;
   logic [NUM_WRDS*WRD_BITS-1:0] o_dat;
   logic                         o_val;
   logic                         i_rdy;
   logic                         o_ovf;

   modport master (
      output i_start, i_iter_target, i_mul, i_mul_val, i_rdy,
      input  o_busy, o_iter_cnt, o_dat, o_val, o_ovf
   );

   modport slave (
      input  i_start, i_iter_target, i_mul, i_mul_val, i_rdy,
      output o_busy, o_iter_cnt, o_dat, o_val, o_ovf
   );

endinterface

// File: rtl/redun_wrd_serial_addsub.sv
// -----------------------------------------------------------------------------
// redun_wrd_serial_addsub
// One word-wide adder/subtractor with a registered 2-bit carry/borrow, used
// word-serially by the result unit.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : clear the carry/borrow register (start of a new serial op)
//   i_en         : advance the carry/borrow register by one word
//   i_sub        : 0 = collapse (a + carry), 1 = subtract (a[W-1:0] - b - borrow)
//   i_a          : redundant/canonical word (WRD_BITS+1 bits)
//   i_b          : modulus word for subtraction
//   o_res        : WRD_BITS result word
//   o_cry        : carry (0..2) or borrow (0..1) out of this word
// -----------------------------------------------------------------------------
module redun_wrd_serial_addsub
   import redun_mont_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_en,
   input  logic                i_sub,
   input  logic [WRD_BITS:0]   i_a,
   input  logic [WRD_BITS-1:0] i_b,
   output logic [WRD_BITS-1:0] o_res,
   output logic [1:0]          o_cry
);

   logic [1:0]          cry;
   logic [WRD_BITS+1:0] sum;

   // Two guard bits: in add mode they hold the carry (max 2), in subtract mode
   // the top bit is the sign of a value in [-2^W, 2^W-1], i.e. the borrow.
   always_comb begin
      if (i_sub) begin
         sum = {2'b00, i_a[WRD_BITS-1:0]} - {2'b00, i_b}
               - {{WRD_BITS{1'b0}}, cry};
      end else begin
         sum = {1'b0, i_a} + {{WRD_BITS{1'b0}}, cry};
      end
      o_res = sum[WRD_BITS-1:0];
      o_cry = i_sub ? {1'b0, sum[WRD_BITS+1]} : sum[WRD_BITS+1:WRD_BITS];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         cry <= 2'b00;
      end else if (i_en) begin
         cry <= o_cry;
      end
   end

endmodule

// File: rtl/redun_mont_result_unit.sv
// -----------------------------------------------------------------------------
// redun_mont_result_unit
// Downstream stage of the repeated-squaring Montgomery core. After start it
// counts squaring results until the programmed target, captures that
// redundant result, collapses the carries word-serially into canonical binary,
// then subtracts P word-serially until the value drops below P (or MAX_SUB
// subtractions succeeded, flagged by o_ovf), and presents it on valid/ready.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : start/target, squaring result input, counters, and the
//                  o_dat/o_val/i_rdy/o_ovf result handshake
// Parameters:
//   CNT_BITS : width of the iteration target and counter
//   MAX_SUB  : successful subtractions after which the result is forced out
// -----------------------------------------------------------------------------
module redun_mont_result_unit
   import redun_mont_pkg::*;
#(
   parameter int CNT_BITS = 64,
   parameter int MAX_SUB  = 4
)(
   input  logic                     i_clk,
   input  logic                     i_rst,
   redun_mont_result_unit_if.slave  bus
);

   localparam int               K_W      = $clog2(MAX_SUB+1);
   localparam int               WI_W     = $clog2(NUM_WRDS);
   localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NUM_WRDS-1);
   localparam logic [IDX_W-1:0] LAST_RES = IDX_W'(NUM_WRDS);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(MAX_SUB-1);

   result_state_t                state;
   logic [CNT_BITS-1:0]          tgt;
   logic [CNT_BITS-1:0]          iter_cnt;
   redun0_t                      wbuf;
   canon_t                       res;
   logic [NUM_WRDS*WRD_BITS-1:0] dif;
   logic [IDX_W-1:0]             idx;
   logic [K_W-1:0]               k;
   logic                         ovf;
   logic                         val;

   logic [CNT_BITS-1:0]          cnt_nxt;
   logic                         cap;
   canon_t                       dif_full;

   logic                         as_clr;
   logic                         as_en;
   logic                         as_sub;
   logic [WRD_BITS:0]            as_a;
   logic [WRD_BITS-1:0]          as_b;
   logic [WRD_BITS-1:0]          as_res;
   logic [1:0]                   as_cry;

   // Counter never passes the latched target.
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c,
                                                   input logic [CNT_BITS-1:0] lim);
      return (c >= lim) ? c : c + CNT_BITS'(1);
   endfunction

   assign cnt_nxt = sat_inc(iter_cnt, tgt);
   assign cap     = (state == ST_COUNT) && bus.i_mul_val && (cnt_nxt == tgt);

   // Complete difference of a pass: earlier words from dif, top word live.
   assign dif_full = {as_res, dif};

   always_comb begin
      as_sub = (state == ST_REDUCE);
      as_en  = (state == ST_COLLAPSE) || (state == ST_REDUCE);
      // Carry is cleared on capture and after the last word of every serial
      // operation so each collapse and each subtraction pass starts fresh.
      as_clr = cap
               || ((state == ST_COLLAPSE) && (idx == LAST_IN))
               || ((state == ST_REDUCE)   && (idx == LAST_RES));
      as_a   = as_sub ? {1'b0, get_wrd(res, idx)} : wbuf[idx[WI_W-1:0]];
      as_b   = get_wrd(P_EXT, idx);
   end

   redun_wrd_serial_addsub u_addsub (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (as_clr),
      .i_en  (as_en),
      .i_sub (as_sub),
      .i_a   (as_a),
      .i_b   (as_b),
      .o_res (as_res),
      .o_cry (as_cry)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         tgt      <= '0;
         iter_cnt <= '0;
         wbuf     <= '0;
         res      <= '0;
         dif      <= '0;
         idx      <= '0;
         k        <= '0;
         ovf      <= 1'b0;
         val      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  tgt      <= (bus.i_iter_target == '0) ? CNT_BITS'(1)
                                                        : bus.i_iter_target;
                  iter_cnt <= '0;
                  state    <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (bus.i_mul_val) begin
                  iter_cnt <= cnt_nxt;
                  if (cap) begin
                     wbuf  <= bus.i_mul;
                     idx   <= '0;
                     state <= ST_COLLAPSE;
                  end
               end
            end

            ST_COLLAPSE: begin
               res[int'(idx)*WRD_BITS +: WRD_BITS] <= as_res;
               if (idx == LAST_IN) begin
                  // Final carry (at most 2) becomes the spare top word.
                  res[NUM_WRDS*WRD_BITS +: WRD_BITS] <= WRD_BITS'(as_cry);
                  idx   <= '0;
                  state <= ST_REDUCE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            ST_REDUCE: begin
               if (idx != LAST_RES) begin
                  dif[int'(idx)*WRD_BITS +: WRD_BITS] <= as_res;
                  idx <= idx + IDX_W'(1);
               end else begin
                  idx <= '0;
                  if (!as_cry[0]) begin
                     // res >= P: keep the difference and try again.
                     res <= dif_full;
                     k   <= k + K_W'(1);
                     if (k == K_LAST) begin
                        ovf   <= 1'b1;
                        state <= ST_OUT;
                     end
                  end else begin
                     state <= ST_OUT;
                  end
               end
            end

            ST_OUT: begin
               if (val && bus.i_rdy) begin
                  val   <= 1'b0;
                  ovf   <= 1'b0;
                  k     <= '0;
                  state <= ST_IDLE;
               end else begin
                  val <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy     = (state != ST_IDLE);
   assign bus.o_iter_cnt = iter_cnt;
   assign bus.o_dat      = res[NUM_WRDS*WRD_BITS-1:0];
   assign bus.o_val      = val;
   assign bus.o_ovf      = ovf;

endmodule

// File: tb/tb_redun_mont_result_unit.sv
module tb_redun_mont_result_unit;
   import redun_mont_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] tgt;
   redun0_t     mul;
   logic        mul_val;
   logic        rdy;

   int n_tests = 0;
   int n_fail  = 0;

   int          lat_a, lat_b;
   logic [63:0] dat_a, dat_b, cnt_a;
   logic        ovf_a, ovf_b;

   always #5 clk = ~clk;

   redun_mont_result_unit_if #(.CNT_BITS(64)) bus_a ();
   redun_mont_result_unit_if #(.CNT_BITS(64)) bus_b ();

   assign bus_a.i_start       = start;
   assign bus_a.i_iter_target = tgt;
   assign bus_a.i_mul         = mul;
   assign bus_a.i_mul_val     = mul_val;
   assign bus_a.i_rdy         = rdy;
   assign bus_b.i_start       = start;
   assign bus_b.i_iter_target = tgt;
   assign bus_b.i_mul         = mul;
   assign bus_b.i_mul_val     = mul_val;
   assign bus_b.i_rdy         = rdy;

   redun_mont_result_unit #(.CNT_BITS(64), .MAX_SUB(4)) dut_a (
      .i_clk (clk), .i_rst (rst), .bus (bus_a));

   redun_mont_result_unit #(.CNT_BITS(64), .MAX_SUB(2)) dut_b (
      .i_clk (clk), .i_rst (rst), .bus (bus_b));

   // Reference: value = sum of words * 2^(16i); subtract P while >= P, at most
   // max_sub times; overflow when the limit was used up.
   function automatic void ref_model(input redun0_t r, input int max_sub,
                                     output logic [63:0] dat, output logic ovf,
                                     output int lat);
      logic [79:0] v;
      int          k;
      int          passes;
      v = '0;
      for (int i = 0; i < NUM_WRDS; i++) v = v + (80'(r[i]) << (16*i));
      k = 0;
      while (k < max_sub && v >= 80'(P)) begin
         v = v - 80'(P);
         k++;
      end
      ovf    = (k == max_sub);
      passes = ovf ? k : k + 1;
      lat    = 1 + NUM_WRDS + passes*(NUM_WRDS+1);
      dat    = v[63:0];
   endfunction

   function automatic redun0_t to_redun(input logic [63:0] x);
      redun0_t r;
      for (int i = 0; i < NUM_WRDS; i++) r[i] = {1'b0, x[16*i +: 16]};
      return r;
   endfunction

   function automatic redun0_t rand_redun();
      redun0_t r;
      for (int i = 0; i < NUM_WRDS; i++) r[i] = 17'($urandom_range(0, 17'h1FFFF));
      return r;
   endfunction

   // Drives one full operation and records what each DUT presents at the
   // first sampling point where its o_val is high (cycle count from capture).
   task automatic run_op(input logic [63:0] t, input redun0_t capv);
      int teff;
      int cyc;
      teff = (t == 0) ? 1 : int'(t);
      @(negedge clk); start = 1'b1; tgt = t;
      @(negedge clk); start = 1'b0;
      for (int j = 1; j <= teff; j++) begin
         mul = (j == teff) ? capv : rand_redun();
         mul_val = 1'b1;
         @(negedge clk);
         mul_val = 1'b0;
         mul = rand_redun();
         if (j != teff) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      lat_a = -1; lat_b = -1; cyc = 0;
      while (lat_a < 0 && cyc <= 200) begin
         if (lat_b < 0 && bus_b.o_val) begin
            lat_b = cyc; dat_b = bus_b.o_dat; ovf_b = bus_b.o_ovf;
         end
         if (bus_a.o_val) begin
            lat_a = cyc; dat_a = bus_a.o_dat; ovf_a = bus_a.o_ovf;
            cnt_a = bus_a.o_iter_cnt;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tgt = '0; mul = '0; mul_val = 1'b0; rdy = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus_a.o_busy); end
      n_tests++; if (bus_a.o_val !== 1'b0) begin n_fail++; $display("FAIL reset_val got %b want 0", bus_a.o_val); end
      n_tests++; if (bus_a.o_dat !== 64'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", bus_a.o_dat); end
      n_tests++; if (bus_a.o_iter_cnt !== 64'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus_a.o_iter_cnt); end
      n_tests++; if (bus_a.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus_a.o_ovf); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_op(64'd3, to_redun(64'h1234));
      n_tests++; if (lat_a !== 10) begin n_fail++; $display("FAIL basic_latency got %0d want 10", lat_a); end
      n_tests++; if (dat_a !== 64'h1234) begin n_fail++; $display("FAIL basic_dat got %h want 1234", dat_a); end
      n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf_a); end
      n_tests++; if (cnt_a !== 64'd3) begin n_fail++; $display("FAIL basic_cnt got %0d want 3", cnt_a); end
      @(negedge clk);
      n_tests++; if (bus_a.o_val !== 1'b0) begin n_fail++; $display("FAIL basic_val_drop got %b want 0", bus_a.o_val); end
      n_tests++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", bus_a.o_busy); end
   endtask

   task automatic test_all_ones();
      redun0_t     capv;
      logic [63:0] e_dat;
      logic        e_ovf;
      int          e_lat;
      for (int i = 0; i < NUM_WRDS; i++) capv[i] = 17'h1FFFF;
      ref_model(capv, 4, e_dat, e_ovf, e_lat);
      run_op(64'd1, capv);
      n_tests++; if (dat_a !== e_dat) begin n_fail++; $display("FAIL ones_dat got %h want %h", dat_a, e_dat); end
      n_tests++; if (ovf_a !== e_ovf) begin n_fail++; $display("FAIL ones_ovf got %b want %b", ovf_a, e_ovf); end
      n_tests++; if (lat_a !== e_lat) begin n_fail++; $display("FAIL ones_latency got %0d want %0d", lat_a, e_lat); end
      n_tests++; if (lat_a > 20) begin n_fail++; $display("FAIL ones_k_bound latency %0d exceeds 20", lat_a); end
      @(negedge clk);
   endtask

   task automatic test_equal_p();
      redun0_t capv;
      capv[3] = 17'h0C1A6; capv[2] = 17'h10000; capv[1] = 17'h00000; capv[0] = 17'h00065;
      run_op(64'd2, capv);
      n_tests++; if (dat_a !== 64'h0) begin n_fail++; $display("FAIL eqp_dat got %h want 0", dat_a); end
      n_tests++; if (lat_a !== 15) begin n_fail++; $display("FAIL eqp_latency got %0d want 15", lat_a); end
      n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL eqp_ovf got %b want 0", ovf_a); end
      @(negedge clk);
   endtask

   task automatic test_hold();
      redun0_t     capv;
      logic [63:0] e_dat;
      logic        e_ovf;
      int          e_lat;
      capv = rand_redun();
      ref_model(capv, 4, e_dat, e_ovf, e_lat);
      rdy = 1'b0;
      run_op(64'd2, capv);
      n_tests++; if (dat_a !== e_dat) begin n_fail++; $display("FAIL hold_dat got %h want %h", dat_a, e_dat); end
      for (int c = 0; c < 20; c++) begin
         mul_val = 1'($urandom_range(0, 1));
         start   = 1'($urandom_range(0, 1));
         tgt     = 64'($urandom_range(0, 5));
         mul     = rand_redun();
         @(negedge clk);
         n_tests++; if (bus_a.o_val !== 1'b1) begin n_fail++; $display("FAIL hold_val cyc %0d got %b want 1", c, bus_a.o_val); end
         n_tests++; if (bus_a.o_dat !== e_dat) begin n_fail++; $display("FAIL hold_dat_stable cyc %0d got %h want %h", c, bus_a.o_dat, e_dat); end
         n_tests++; if (bus_a.o_iter_cnt !== 64'd2) begin n_fail++; $display("FAIL hold_cnt cyc %0d got %0d want 2", c, bus_a.o_iter_cnt); end
      end
      start = 1'b0; mul_val = 1'b0; rdy = 1'b1;
      @(negedge clk);
      n_tests++; if (bus_a.o_val !== 1'b0) begin n_fail++; $display("FAIL hold_release_val got %b want 0", bus_a.o_val); end
      n_tests++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_idle got %b want 0", bus_a.o_busy); end
   endtask

   // Second instance has MAX_SUB=2, so any collapsed value >= 2P overflows.
   task automatic test_ovf();
      redun0_t     capv;
      logic [63:0] e_dat, ea_dat;
      logic        e_ovf, ea_ovf;
      int          e_lat, ea_lat;
      for (int n = 0; n < 4; n++) begin
         capv = rand_redun();
         capv[3] = 17'($urandom_range(17'h18400, 17'h1FFFF));
         if (n == 0) for (int i = 0; i < NUM_WRDS; i++) capv[i] = 17'h1FFFF;
         ref_model(capv, 2, e_dat, e_ovf, e_lat);
         ref_model(capv, 4, ea_dat, ea_ovf, ea_lat);
         run_op(64'd1, capv);
         n_tests++; if (ovf_b !== e_ovf) begin n_fail++; $display("FAIL ovf_flag[%0d] got %b want %b", n, ovf_b, e_ovf); end
         n_tests++; if (dat_b !== e_dat) begin n_fail++; $display("FAIL ovf_dat[%0d] got %h want %h", n, dat_b, e_dat); end
         n_tests++; if (lat_b !== e_lat) begin n_fail++; $display("FAIL ovf_latency[%0d] got %0d want %0d", n, lat_b, e_lat); end
         n_tests++; if (dat_a !== ea_dat) begin n_fail++; $display("FAIL ovf_main_dat[%0d] got %h want %h", n, dat_a, ea_dat); end
         n_tests++; if (ovf_a !== ea_ovf) begin n_fail++; $display("FAIL ovf_main_flag[%0d] got %b want %b", n, ovf_a, ea_ovf); end
         @(negedge clk);
         n_tests++; if (bus_b.o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear[%0d] got %b want 0", n, bus_b.o_ovf); end
      end
   endtask

   task automatic test_back_to_back();
      redun0_t     capv;
      logic [63:0] t;
      logic [63:0] e_dat, eb_dat;
      logic        e_ovf, eb_ovf;
      int          e_lat, eb_lat;
      for (int n = 0; n < 12; n++) begin
         capv = rand_redun();
         t = 64'($urandom_range(0, 3));
         ref_model(capv, 4, e_dat, e_ovf, e_lat);
         ref_model(capv, 2, eb_dat, eb_ovf, eb_lat);
         run_op(t, capv);
         n_tests++; if (dat_a !== e_dat) begin n_fail++; $display("FAIL rnd_dat[%0d] got %h want %h", n, dat_a, e_dat); end
         n_tests++; if (lat_a !== e_lat) begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat_a, e_lat); end
         n_tests++; if (ovf_a !== e_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] got %b want %b", n, ovf_a, e_ovf); end
         n_tests++; if (cnt_a !== ((t == 0) ? 64'd1 : t)) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, cnt_a, (t == 0) ? 64'd1 : t); end
         n_tests++; if (dat_b !== eb_dat || ovf_b !== eb_ovf) begin n_fail++; $display("FAIL rnd_b[%0d] got %h/%b want %h/%b", n, dat_b, ovf_b, eb_dat, eb_ovf); end
         @(negedge clk);
      end
   endtask

   task automatic test_rst_reduce();
      redun0_t     capv;
      logic [63:0] e_dat;
      logic        e_ovf;
      int          e_lat;
      for (int i = 0; i < NUM_WRDS; i++) capv[i] = 17'h1FFFF;
      @(negedge clk); start = 1'b1; tgt = 64'd1;
      @(negedge clk); start = 1'b0; mul = capv; mul_val = 1'b1;
      @(negedge clk); mul_val = 1'b0;
      repeat (6) @(negedge clk);
      n_tests++; if (bus_a.o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", bus_a.o_busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++; if (bus_a.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus_a.o_busy); end
      n_tests++; if (bus_a.o_val !== 1'b0) begin n_fail++; $display("FAIL rst_mid_val got %b want 0", bus_a.o_val); end
      n_tests++; if (bus_a.o_dat !== 64'h0) begin n_fail++; $display("FAIL rst_mid_dat got %h want 0", bus_a.o_dat); end
      n_tests++; if (bus_a.o_iter_cnt !== 64'h0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d want 0", bus_a.o_iter_cnt); end
      capv = rand_redun();
      ref_model(capv, 4, e_dat, e_ovf, e_lat);
      run_op(64'd0, capv);
      n_tests++; if (dat_a !== e_dat) begin n_fail++; $display("FAIL t0_dat got %h want %h", dat_a, e_dat); end
      n_tests++; if (lat_a !== e_lat) begin n_fail++; $display("FAIL t0_latency got %0d want %0d", lat_a, e_lat); end
      n_tests++; if (cnt_a !== 64'd1) begin n_fail++; $display("FAIL t0_cnt got %0d want 1", cnt_a); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_equal_p();
      test_hold();
      test_ovf();
      test_back_to_back();
      test_rst_reduce();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/redun_mont_result_unit.md
Name: redun_mont_result_unit

Overview:
- Downstream stage of the repeated-squaring Montgomery core.
- Counts squaring results from the core until a programmed iteration target is reached.
- Captures that redundant-form result and collapses the carries word-serially to canonical binary.
- Reduces the value below modulus P by repeated word-serial trial subtraction, then presents it on a valid/ready output.

Parameters:
- CNT_BITS, 64, width of iteration target and counter.
- MAX_SUB, 4, maximum successful subtractions of P before the result is forced out with an overflow flag.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; latches i_iter_target. Ignored unless state is IDLE.
- i_iter_target  in  CNT_BITS  number of squarings to wait for; a value of 0 is treated as 1.
- i_mul  in  redun0_t  redundant result from the squaring core: NUM_WRDS words of WRD_BITS+1 bits.
- i_mul_val  in  1  qualifies i_mul; a single-cycle pulse per squaring.
- o_busy  out  1  high in every state except IDLE.
- o_iter_cnt  out  CNT_BITS  count of i_mul_val pulses seen since start.
- o_dat  out  NUM_WRDS*WRD_BITS  reduced result, less than P unless o_ovf=1.
- o_val  out  1  output valid; held until i_rdy.
- i_rdy  in  1  downstream accept.
- o_ovf  out  1  valid with o_val; set when MAX_SUB was hit without reaching a value below P.

Behaviour:
- Reset: state=IDLE; o_busy=0, o_iter_cnt=0, o_dat=0, o_val=0, o_ovf=0; internal buffers and carry cleared.
- Reset asserted mid-operation aborts immediately to IDLE with the same values; any held o_val is dropped.
- State is one-hot: IDLE, COUNT, COLLAPSE, REDUCE, OUT.
- IDLE:
  - On i_start: latch target T (0 maps to 1), clear o_iter_cnt, go to COUNT.
  - i_mul_val is ignored.
- COUNT:
  - Each i_mul_val increments o_iter_cnt.
  - On the i_mul_val that makes the count equal T: copy i_mul into the word buffer, clear word index and carry, go to COLLAPSE.
  - i_start is ignored while busy.
- COLLAPSE: NUM_WRDS cycles, one word per cycle.
  - s = buf[i] (WRD_BITS+1 bits) + carry (2 bits).
  - res[i] = s[WRD_BITS-1:0]; carry = s>>WRD_BITS (maximum value 2).
  - After word NUM_WRDS-1: res[NUM_WRDS] = carry, zero-extended to WRD_BITS.
  - res is (NUM_WRDS+1)*WRD_BITS bits wide.
- REDUCE: one pass takes NUM_WRDS+1 cycles.
  - Word-serial computation diff[i] = res[i] - P[i] - borrow, with P zero-extended to NUM_WRDS+1 words.
  - End of pass, final borrow=0: res<=diff, increment subtraction count k. If k==MAX_SUB, set o_ovf and go to OUT; otherwise start another pass.
  - End of pass, final borrow=1: res is unchanged, go to OUT.
  - A value exactly equal to P therefore becomes 0.
- OUT:
  - o_val=1; o_dat = res[NUM_WRDS-1:0], stable while o_val is high.
  - On the cycle where o_val&&i_rdy: the next cycle is IDLE with o_val=0; o_ovf and k are cleared.
  - i_mul_val arriving during COLLAPSE, REDUCE or OUT is ignored and not counted.
- Latency: o_val rises 1+NUM_WRDS+(k+1)*(NUM_WRDS+1) cycles after the capturing i_mul_val edge, with k = number of successful subtractions.
- o_iter_cnt saturates at T and holds until the next start.

Decomposition:
- redun_mont_pkg already holds NUM_WRDS, WRD_BITS, P and redun0_t. Add to it:
  - result_state_t: one-hot state enum.
  - canon_t: (NUM_WRDS+1)*WRD_BITS flat vector.
  - function get_wrd(canon_t, idx).
- Sub-module redun_wrd_serial_addsub: one word-wide adder/subtractor with a 2-bit carry/borrow register and a mode input (collapse add / subtract P). Shared by COLLAPSE and REDUCE.

Test Plan (test package: NUM_WRDS=4, WRD_BITS=16, P=0xC1A7_0000_0000_0065):
- Reset, then T=3 and three i_mul_val pulses with i_mul = to_redun(0x1234) -> o_val after 1+4+5=10 cycles; o_dat=0x1234, o_ovf=0, o_iter_cnt=3.
- Captured word values all 0x1FFFF (every bit of every word set) -> COLLAPSE carries ripple; res = 2^64+... correctly reduced; o_dat matches the reference model's (collapsed mod P) value; k reported ≤2.
- Input equals P (redundant form with word bits set) -> o_dat=0, k=1, latency 15.
- i_rdy held low for 20 cycles in OUT -> o_val and o_dat stable throughout; extra i_mul_val and i_start pulses ignored; o_iter_cnt unchanged.
- Input collapsed value ≥ 5*P, MAX_SUB=4 -> o_ovf=1 after 4 passes; o_dat = input-4P.
- i_rst pulsed during REDUCE -> next cycle o_busy=0, o_val=0, o_dat=0; a fresh start with T=0 completes on the first i_mul_val.
